// File: rtl/snax_csr_pkg.sv
// Shared constants and address-decode helpers for the SNAX CSR responder.
package snax_csr_pkg;

  localparam int unsigned CsrDataWidth = 32;
  localparam int unsigned CsrAddrWidth = 32;

  // True when addr falls strictly below bound (0-based CSR index).
  function automatic logic addr_below(input logic [CsrAddrWidth-1:0] addr,
                                      input int unsigned bound);
    return addr < CsrAddrWidth'(bound);
  endfunction

endpackage

// File: rtl/snax_csr_responder_if.sv
// CSR request/response bus between the host-side master and the responder.
interface snax_csr_responder_if;
  import snax_csr_pkg::*;

  logic [CsrDataWidth-1:0] csr_req_data_i;
  logic [CsrAddrWidth-1:0] csr_req_addr_i;
  logic                    csr_req_write_i;
  logic                    csr_req_valid_i;
  logic                    csr_req_ready_o;
  logic [CsrDataWidth-1:0] csr_rsp_data_o;
  logic                    csr_rsp_valid_o;
  logic                    csr_rsp_ready_i;

  modport slave (
    input  csr_req_data_i, csr_req_addr_i, csr_req_write_i, csr_req_valid_i,
    input  csr_rsp_ready_i,
    output csr_req_ready_o, csr_rsp_data_o, csr_rsp_valid_o
  );

  modport master (
    output csr_req_data_i, csr_req_addr_i, csr_req_write_i, csr_req_valid_i,
    output csr_rsp_ready_i,
    input  csr_req_ready_o, csr_rsp_data_o, csr_rsp_valid_o
  );
endinterface

// File: rtl/snax_csr_rsp_reg.sv
// One-entry valid/ready register holding the read response; it can accept a
// new entry in the same cycle the current one drains, so there is no bubble.
module snax_csr_rsp_reg
  import snax_csr_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [CsrDataWidth-1:0] in_data_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [CsrDataWidth-1:0] out_data_o
);

  logic                    valid_q;
  logic [CsrDataWidth-1:0] data_q;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  // Load on accept, clear on drain, otherwise hold valid and data stable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_valid_i && in_ready_o) begin
      valid_q <= 1'b1;
      data_q  <= in_data_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/snax_csr_responder.sv
// CSR responder: config/control RW register file, RO status window, start
// pulse generation and a registered read response.
module snax_csr_responder
  import snax_csr_pkg::*;
#(
  parameter int unsigned NumRwCsr = 8,
  parameter int unsigned NumRoCsr = 2
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  snax_csr_responder_if.slave                    csr,
  output logic [NumRwCsr-1:0][CsrDataWidth-1:0]  csr_rw_o,
  input  logic [NumRoCsr-1:0][CsrDataWidth-1:0]  csr_ro_i,
  output logic                                   acc_start_o,
  input  logic                                   acc_busy_i
);

  localparam logic [CsrAddrWidth-1:0] CtrlAddr = CsrAddrWidth'(NumRwCsr - 1);

  logic [NumRwCsr-1:0][CsrDataWidth-1:0] csr_rw_q;
  logic                                  start_q;
  logic                                  addr_is_rw;
  logic                                  req_ready;
  logic                                  rsp_in_ready;
  logic                                  rd_hs;
  logic                                  wr_hs;
  logic [CsrDataWidth-1:0]               rd_data;
  logic                                  rsp_valid;
  logic [CsrDataWidth-1:0]               rsp_data;

  assign addr_is_rw = addr_below(csr.csr_req_addr_i, NumRwCsr);

  // Reads need a free response slot; RW writes stall while the accelerator runs.
  always_comb begin
    req_ready = 1'b0;
    if (rst_ni) begin
      if (csr.csr_req_write_i) req_ready = !(acc_busy_i && addr_is_rw);
      else                     req_ready = rsp_in_ready;
    end
  end

  assign rd_hs = csr.csr_req_valid_i && req_ready && !csr.csr_req_write_i;
  assign wr_hs = csr.csr_req_valid_i && req_ready &&  csr.csr_req_write_i;

  // Read mux over RW and RO windows; anything else reads as zero.
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NumRwCsr; i++) begin
      if (csr.csr_req_addr_i == CsrAddrWidth'(i)) rd_data = csr_rw_q[i];
    end
    for (int unsigned j = 0; j < NumRoCsr; j++) begin
      if (csr.csr_req_addr_i == CsrAddrWidth'(NumRwCsr + j)) rd_data = csr_ro_i[j];
    end
  end

  // Register file writes; control bit0 is a self-clearing start request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      csr_rw_q <= '0;
      start_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (wr_hs) begin
        for (int unsigned i = 0; i < NumRwCsr - 1; i++) begin
          if (csr.csr_req_addr_i == CsrAddrWidth'(i)) csr_rw_q[i] <= csr.csr_req_data_i;
        end
        if (csr.csr_req_addr_i == CtrlAddr) begin
          csr_rw_q[NumRwCsr-1] <= {csr.csr_req_data_i[CsrDataWidth-1:1], 1'b0};
          start_q              <= csr.csr_req_data_i[0];
        end
      end
    end
  end

  snax_csr_rsp_reg i_rsp_reg (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (rd_hs),
    .in_ready_o  (rsp_in_ready),
    .in_data_i   (rd_data),
    .out_valid_o (rsp_valid),
    .out_ready_i (csr.csr_rsp_ready_i),
    .out_data_o  (rsp_data)
  );

  assign csr.csr_req_ready_o = req_ready;
  assign csr.csr_rsp_valid_o = rsp_valid;
  assign csr.csr_rsp_data_o  = rsp_data;
  assign csr_rw_o            = csr_rw_q;
  assign acc_start_o         = start_q;

endmodule

// File: tb/tb_snax_csr_responder.sv
// Randomized and directed bench for snax_csr_responder with a behavioural
// reference model of the CSR map and the response slot.
module tb_snax_csr_responder;

  localparam int unsigned NRW = 8;
  localparam int unsigned NRO = 2;

  logic                      clk = 1'b0;
  logic                      rst_ni = 1'b0;
  logic [NRW-1:0][31:0]      csr_rw;
  logic [NRO-1:0][31:0]      csr_ro;
  logic                      acc_start;
  logic                      acc_busy;

  snax_csr_responder_if bus ();

  snax_csr_responder #(.NumRwCsr(NRW), .NumRoCsr(NRO)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .csr         (bus.slave),
    .csr_rw_o    (csr_rw),
    .csr_ro_i    (csr_ro),
    .acc_start_o (acc_start),
    .acc_busy_i  (acc_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state
  logic [31:0] m_rw [NRW];
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_start;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NRW; i++) m_rw[i] = '0;
    m_valid = 1'b0;
    m_data  = '0;
    m_start = 1'b0;
  endtask

  // One bus cycle, entered at a falling edge, leaves at the next falling edge.
  task automatic step(input logic v, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic rr, input logic b);
    logic        exp_ready, hs;
    logic [31:0] rdat;
    check("rsp_valid", 32'(bus.csr_rsp_valid_o), 32'(m_valid));
    if (m_valid) check("rsp_data", bus.csr_rsp_data_o, m_data);
    check("acc_start", 32'(acc_start), 32'(m_start));
    for (int i = 0; i < NRW; i++) check($sformatf("csr_rw[%0d]", i), csr_rw[i], m_rw[i]);

    bus.csr_req_valid_i = v;
    bus.csr_req_write_i = w;
    bus.csr_req_addr_i  = a;
    bus.csr_req_data_i  = d;
    bus.csr_rsp_ready_i = rr;
    acc_busy            = b;
    #1;
    if (w) exp_ready = !(b && a < NRW);
    else   exp_ready = !m_valid || rr;
    check("req_ready", 32'(bus.csr_req_ready_o), 32'(exp_ready));

    hs = v && exp_ready;
    if (a < NRW)            rdat = m_rw[int'(a)];
    else if (a < NRW + NRO) rdat = csr_ro[int'(a - NRW)];
    else                    rdat = 32'h0;

    m_start = hs && w && (a == NRW - 1) && d[0];
    if (hs && w && a < NRW) m_rw[int'(a)] = (a == NRW - 1) ? (d & ~32'h1) : d;
    if (hs && !w) begin
      m_valid = 1'b1;
      m_data  = rdat;
    end else if (rr) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rsp_valid"}, 32'(bus.csr_rsp_valid_o), 32'h0);
    check({tag, "_rsp_data"}, bus.csr_rsp_data_o, 32'h0);
    check({tag, "_acc_start"}, 32'(acc_start), 32'h0);
    check({tag, "_req_ready"}, 32'(bus.csr_req_ready_o), 32'h0);
    for (int i = 0; i < NRW; i++) check($sformatf("%s_rw[%0d]", tag, i), csr_rw[i], 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    bus.csr_req_valid_i = 1'b1;
    bus.csr_req_write_i = 1'b0;
    bus.csr_req_addr_i  = '0;
    bus.csr_req_data_i  = '0;
    bus.csr_rsp_ready_i = 1'b1;
    acc_busy            = 1'b0;
    csr_ro              = '0;
    model_reset();

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_ni = 1'b1;

    // Config write then read back
    step(1, 1, 0, 32'hDEADBEEF, 1, 0);
    step(1, 0, 0, 32'h0, 1, 0);
    check("cfg0_value", csr_rw[0], 32'hDEADBEEF);
    step(0, 0, 0, 32'h0, 1, 0);

    // Control write with start, read back with bit0 cleared
    step(1, 1, NRW - 1, 32'h5, 1, 0);
    check("start_pulse", 32'(acc_start), 32'h1);
    step(1, 0, NRW - 1, 32'h0, 1, 0);
    check("start_done", 32'(acc_start), 32'h0);
    check("ctrl_readback", bus.csr_rsp_data_o, 32'h4);
    step(0, 0, 0, 32'h0, 1, 0);

    // Busy stalls RW writes but not reads
    repeat (3) step(1, 1, 1, 32'hA5A5_0001, 1, 1);
    step(1, 0, 2, 32'h0, 1, 1);
    step(1, 1, 1, 32'hA5A5_0001, 1, 0);
    step(0, 0, 0, 32'h0, 1, 0);

    // Back-to-back reads, then unmapped
    step(1, 1, 2, 32'h2222_2222, 1, 0);
    step(1, 0, 0, 32'h0, 1, 0);
    step(1, 0, 1, 32'h0, 1, 0);
    step(1, 0, 2, 32'h0, 1, 0);
    step(1, 0, 32'hFF, 32'h0, 1, 0);
    step(0, 0, 0, 32'h0, 1, 0);

    // RO read held under backpressure
    csr_ro[0] = 32'h1234;
    csr_ro[1] = 32'h5678;
    step(1, 0, NRW, 32'h0, 0, 0);
    repeat (3) step(1, 0, 0, 32'h0, 0, 0);
    check("ro_hold_data", bus.csr_rsp_data_o, 32'h1234);

    // Reset while a response is pending
    #2 rst_ni = 1'b0;
    #1 check_all_zero("midreset");
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int j = 0; j < NRO; j++) csr_ro[j] = $urandom;
      r = int'($urandom_range(0, 15));
      if (r < 12)      a = $urandom_range(0, NRW + NRO + 1);
      else if (r < 14) a = 32'hFF;
      else             a = $urandom;
      step(($urandom_range(0, 9) < 8), $urandom_range(0, 1) == 1, a, $urandom,
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3));
    end
    step(0, 0, 0, 32'h0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/snax_csr_responder.md
SNAX_CSR_RESPONDER -- requirements
Module: snax_csr_responder

Interface
REQ-001 SHALL have parameter NumRwCsr, default 8, number of read/write CSRs (min 2).
REQ-002 SHALL have parameter NumRoCsr, default 2, number of read-only status CSRs (min 1).
REQ-003 SHALL have port clk_i  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port csr_req_data_i  in  32  write data.
REQ-006 SHALL have port csr_req_addr_i  in  32  CSR index, already offset-corrected to 0-based.
REQ-007 SHALL have port csr_req_write_i  in  1  1 = write, 0 = read.
REQ-008 SHALL have port csr_req_valid_i  in  1  request valid.
REQ-009 SHALL have port csr_req_ready_o  out  1  request accepted.
REQ-010 SHALL have port csr_rsp_data_o  out  32  read data.
REQ-011 SHALL have port csr_rsp_valid_o  out  1  response valid.
REQ-012 SHALL have port csr_rsp_ready_i  in  1  response consumed.
REQ-013 SHALL have port csr_rw_o  out  NumRwCsr x 32  RW register contents to accelerator.
REQ-014 SHALL have port csr_ro_i  in  NumRoCsr x 32  status values from accelerator.
REQ-015 SHALL have port acc_start_o  out  1  one-cycle start pulse.
REQ-016 SHALL have port acc_busy_i  in  1  accelerator running.

Function
REQ-017 Address map SHALL be: 0..NumRwCsr-2 config RW; NumRwCsr-1 control; NumRwCsr..NumRwCsr+NumRoCsr-1 RO; above that unmapped.
REQ-018 A transfer SHALL occur only on a cycle with csr_req_valid_i && csr_req_ready_o.
REQ-019 Only reads SHALL produce a response; writes SHALL complete silently on handshake.
REQ-020 Read data SHALL be registered: csr_rsp_valid_o rises the cycle after the handshake (latency 1).
REQ-021 csr_rsp_valid_o/csr_rsp_data_o SHALL hold stable until csr_rsp_ready_i is sampled high.
REQ-022 Read handshake SHALL be allowed when !csr_rsp_valid_o || csr_rsp_ready_i; on simultaneous drain and new read, valid stays 1 and data updates (back-to-back, no bubble).
REQ-023 Write handshake to config/control SHALL be blocked (ready=0) while acc_busy_i=1; reads and writes to RO/unmapped SHALL not be blocked by busy.
REQ-024 Write to config register SHALL update csr_rw_o[addr] the next cycle.
REQ-025 Write to control with data[0]=1 SHALL raise acc_start_o for exactly the next cycle; stored control value SHALL have bit0 cleared (bit0 reads back 0).
REQ-026 Writes to RO or unmapped addresses SHALL be accepted and ignored.
REQ-027 Read of unmapped address SHALL return 32'h0; read of RO returns csr_ro_i sampled at handshake.
REQ-028 Read of a register written in the same cycle is impossible (one request per cycle); a read directly after a write SHALL return the new value.

Reset
REQ-029 On rst_ni low, asynchronously: csr_rw_o all 0, csr_rsp_valid_o 0, csr_rsp_data_o 0, acc_start_o 0.
REQ-030 csr_req_ready_o SHALL be 0 while in reset; a pending response SHALL be dropped by a mid-operation reset.

Structure
REQ-031 Shared package snax_csr_pkg SHALL hold CsrDataWidth=32 and address-decode helper constants.
REQ-032 Response register SHALL be a sub-module snax_csr_rsp_reg (1-entry valid/ready register); decode and register file stay in the top.

Verification
REQ-033 Write 0xDEADBEEF to addr 0, then read addr 0 -> csr_rw_o[0]=0xDEADBEEF next cycle; response 0xDEADBEEF one cycle after read handshake.
REQ-034 Write 0x5 to addr NumRwCsr-1 with acc_busy_i=0 -> acc_start_o high exactly one cycle; read back returns 0x4.
REQ-035 acc_busy_i=1, write addr 1 -> csr_req_ready_o=0 until busy falls, then accepted; read during busy accepted immediately.
REQ-036 Read addr NumRwCsr with csr_ro_i[0]=0x1234, csr_rsp_ready_i=0 for 3 cycles -> valid/data 0x1234 held stable, req_ready=0 for further reads.
REQ-037 Back-to-back reads addr 0,1,2 with rsp_ready=1 -> three consecutive valid responses, no bubbles; read addr 0xFF -> 0x0.
REQ-038 Assert rst_ni low while csr_rsp_valid_o=1 -> valid and all outputs 0 immediately.
